// File: rtl/tracer_nibble_host_pkg.sv
// rtl/tracer_nibble_host_pkg.sv - shared constants, state type and nibble select for the tracer host
// Contents:
//   Q6.10 format widths, wrapper pad widths, wrapper step numbers,
//   state_t   : host FSM states
//   nibble_at : nibble idx of an operand, idx 0 = most significant nibble
package tracer_pkg;

   localparam int Q_INT    = 6;
   localparam int Q_FRAC   = 10;
   localparam int Q_W      = Q_INT + Q_FRAC;
   localparam int NIBBLE_W = 4;
   localparam int BYTE_W   = 8;

   // Wrapper steps at which the low and high result bytes are presented.
   localparam int STEP_LO  = 4;
   localparam int STEP_HI  = 5;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CAP_LO,
      CAP_HI
   } state_t;

   function automatic logic [NIBBLE_W-1:0] nibble_at(input logic [Q_W-1:0] op,
                                                     input logic [1:0]     idx);
      logic [Q_W-1:0] shifted;
      shifted = op << (NIBBLE_W * int'(idx));
      return shifted[Q_W-1 -: NIBBLE_W];
   endfunction

endpackage

// File: rtl/tracer_nibble_host_if.sv
// rtl/tracer_nibble_host_if.sv - operand and result streams of the tracer host
// Signals:
//   s_data/s_abs/s_valid/s_ready : operand stream (Q6.10 + abs flag)
//   m_data/m_valid/m_ready       : reciprocal result stream (Q6.10)
// Modports:
//   master : producer of operands / consumer of results
//   slave  : the tracer host itself
interface tracer_nibble_host_if;
   import tracer_pkg::*;

   logic [Q_W-1:0] s_data;
   logic           s_abs;
   logic           s_valid;
   logic           s_ready;
   logic [Q_W-1:0] m_data;
   logic           m_valid;
   logic           m_ready;

   modport master (
      output s_data, s_abs, s_valid, m_ready,
      input  s_ready, m_data, m_valid
   );

   modport slave (
      input  s_data, s_abs, s_valid, m_ready,
      output s_ready, m_data, m_valid
   );

endinterface

// File: rtl/tracer_nibble_host.sv
// rtl/tracer_nibble_host.sv - feeds one operand at a time into the nibble-serial tracer wrapper and collects its result
// Ports:
//   clk      : clock shared with the tracer wrapper
//   reset    : asynchronous active-high reset
//   bus      : operand/result streams (slave modport)
//   t_reset  : wrapper synchronous reset
//   t_abs    : wrapper abs mode, held for the whole operation
//   t_nibble : wrapper nibble input, MSB nibble first
//   t_byte   : wrapper output byte (low byte at step 4, high byte at step 5)
//   busy     : an operation is in flight
module tracer_nibble_host
   import tracer_pkg::*;
#(
   parameter bit IDLE_HOLD_RESET = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   tracer_nibble_host_if.slave bus,
   output logic                t_reset,
   output logic                t_abs,
   output logic [NIBBLE_W-1:0] t_nibble,
   input  logic [BYTE_W-1:0]   t_byte,
   output logic                busy
);

   state_t              state_q, state_d;
   logic [1:0]          phase_q, phase_d;
   logic [Q_W-1:0]      op_q, op_d;
   logic [Q_W-1:0]      m_data_q, m_data_d;
   logic                m_valid_q, m_valid_d;
   logic                t_reset_d, t_abs_d;
   logic [NIBBLE_W-1:0] t_nibble_d;
   logic                s_ready;
   logic                accept;

   assign bus.s_ready = s_ready;
   assign bus.m_data  = m_data_q;
   assign bus.m_valid = m_valid_q;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      op_d       = op_q;
      m_data_d   = m_data_q;
      m_valid_d  = m_valid_q;
      t_reset_d  = t_reset;
      t_abs_d    = t_abs;
      t_nibble_d = t_nibble;

      busy = (state_q != IDLE);
      // Without a held reset the wrapper is only step-aligned when t_reset
      // was high during the accept cycle, so accept waits for it.
      s_ready = (state_q == IDLE) && (!m_valid_q || bus.m_ready) &&
                (IDLE_HOLD_RESET || t_reset);
      accept  = bus.s_valid && s_ready;

      if (m_valid_q && bus.m_ready)
         m_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d       = bus.s_data;
               t_abs_d    = bus.s_abs;
               t_reset_d  = 1'b0;
               t_nibble_d = nibble_at(bus.s_data, 2'd0);
               phase_d    = 2'd0;
               state_d    = LOAD;
            end else if (IDLE_HOLD_RESET) begin
               t_reset_d = 1'b1;
            end else begin
               // Arm the wrapper reset one cycle ahead of a pending operand.
               t_reset_d = bus.s_valid;
            end
         end
         LOAD: begin
            if (phase_q == 2'(STEP_LO - 1)) begin
               t_nibble_d = '0;
               state_d    = CAP_LO;
            end else begin
               phase_d    = phase_q + 2'd1;
               t_nibble_d = nibble_at(op_q, phase_q + 2'd1);
            end
         end
         CAP_LO: begin
            m_data_d[BYTE_W-1:0] = t_byte;
            state_d              = CAP_HI;
         end
         CAP_HI: begin
            m_data_d[Q_W-1:BYTE_W] = t_byte;
            m_valid_d              = 1'b1;
            t_reset_d              = 1'b1;
            state_d                = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         op_q      <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         t_reset   <= 1'b1;
         t_abs     <= 1'b0;
         t_nibble  <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         op_q      <= op_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         t_reset   <= t_reset_d;
         t_abs     <= t_abs_d;
         t_nibble  <= t_nibble_d;
      end
   end

endmodule

// File: tb/tb_tracer_nibble_host.sv
// tb/tb_tracer_nibble_host.sv - scoreboard bench for tracer_nibble_host with a behavioural tracer wrapper
module tb_tracer_nibble_host;
   import tracer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tracer_nibble_host_if if0();
   tracer_nibble_host_if if1();

   logic [15:0] sd[2];
   logic        sa[2], sv[2], mr[2];
   logic        rdy[2], mv[2];
   logic [15:0] md[2];
   logic        t_reset[2], t_abs[2], busy[2];
   logic [3:0]  t_nib[2];
   logic [7:0]  t_byte[2];

   assign if0.s_data = sd[0];  assign if0.s_abs = sa[0];
   assign if0.s_valid = sv[0]; assign if0.m_ready = mr[0];
   assign if1.s_data = sd[1];  assign if1.s_abs = sa[1];
   assign if1.s_valid = sv[1]; assign if1.m_ready = mr[1];
   assign rdy[0] = if0.s_ready; assign mv[0] = if0.m_valid; assign md[0] = if0.m_data;
   assign rdy[1] = if1.s_ready; assign mv[1] = if1.m_valid; assign md[1] = if1.m_data;

   tracer_nibble_host #(.IDLE_HOLD_RESET(1'b1)) dut0 (
      .clk(clk), .reset(rst), .bus(if0), .t_reset(t_reset[0]), .t_abs(t_abs[0]),
      .t_nibble(t_nib[0]), .t_byte(t_byte[0]), .busy(busy[0]));

   tracer_nibble_host #(.IDLE_HOLD_RESET(1'b0)) dut1 (
      .clk(clk), .reset(rst), .bus(if1), .t_reset(t_reset[1]), .t_abs(t_abs[1]),
      .t_nibble(t_nib[1]), .t_byte(t_byte[1]), .busy(busy[1]));

   // Golden reciprocal: 1/x in Q6.10 is 2^20/x, truncated toward zero,
   // saturated to 16-bit signed; 1/0 gives the positive maximum.
   function automatic logic [15:0] recip(input logic [15:0] d, input logic a);
      int x, q;
      x = int'($signed(d));
      if (a && x < 0) x = -x;
      if (x == 0) return 16'h7FFF;
      q = 1048576 / x;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      return 16'(q);
   endfunction

   // Behavioural tracer wrapper: six steps, nibbles in at steps 0-3,
   // low byte out at step 4, high byte out at step 5.
   int          step[2];
   logic [15:0] wsh[2];
   logic [15:0] wres[2];

   initial for (int k = 0; k < 2; k++) begin
      step[k] = 0; wsh[k] = '0; wres[k] = '0;
   end

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (t_reset[k]) begin
            step[k] <= 0;
         end else begin
            if (step[k] < 4) wsh[k] <= {wsh[k][11:0], t_nib[k]};
            if (step[k] == 3) wres[k] <= recip({wsh[k][11:0], t_nib[k]}, t_abs[k]);
            step[k] <= (step[k] == 5) ? 0 : step[k] + 1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         t_byte[k] = 8'h5A ^ 8'(step[k]);
         if (step[k] == 4) t_byte[k] = wres[k][7:0];
         if (step[k] == 5) t_byte[k] = wres[k][15:8];
      end
   end

   // Scoreboard
   typedef struct {
      int          k;
      logic [15:0] d;
      logic        a;
      int          acc;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   int   ncyc  = 0;
   bit   rnd_mr = 1'b0;

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", name, k, act, req, $time);
      end
   endtask

   function automatic int find(input int k);
      for (int i = 0; i < sbq.size(); i++)
         if (sbq[i].k == k) return i;
      return -1;
   endfunction

   function automatic int pending(input int k);
      int n = 0;
      for (int i = 0; i < sbq.size(); i++)
         if (sbq[i].k == k) n++;
      return n;
   endfunction

   // Monitor: samples on the falling edge, away from the active edge.
   logic        pmv[2], pmr[2];
   logic [15:0] pmd[2];
   initial for (int k = 0; k < 2; k++) begin
      pmv[k] = 1'b0; pmr[k] = 1'b0; pmd[k] = '0;
   end

   always @(negedge clk) begin
      int idx;
      ncyc <= ncyc + 1;
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            idx = find(k);
            if (busy[k]) begin
               chk("ready_while_busy", k, 32'(rdy[k]), 0);
               if (idx >= 0) chk("t_abs_hold", k, 32'(t_abs[k]), 32'(sbq[idx].a));
            end
            if (mv[k] && !pmv[k]) begin
               if (idx >= 0) chk("latency", k, ncyc, sbq[idx].acc + 6);
               else chk("unexpected_valid", k, 1, 0);
            end
            if (pmv[k] && !pmr[k]) begin
               chk("hold_valid", k, 32'(mv[k]), 1);
               chk("hold_data", k, 32'(md[k]), 32'(pmd[k]));
            end
            if (mv[k] && !mr[k]) chk("blocked_ready", k, 32'(rdy[k]), 0);
            if (mv[k] && mr[k] && idx >= 0) begin
               chk("result", k, 32'(md[k]), 32'(sbq[idx].d));
               sbq.delete(idx);
            end
         end
         pmv[k] <= mv[k];
         pmr[k] <= mr[k];
         pmd[k] <= md[k];
      end
   end

   // Random m_ready backpressure, driven just after each rising edge.
   always begin
      @(posedge clk);
      #1;
      if (rnd_mr)
         for (int k = 0; k < 2; k++) mr[k] = ($urandom_range(0, 3) != 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an operand and wait for its accept edge; returns at edge+1.
   task automatic send(input int k, input logic [15:0] d, input logic a, input logic [15:0] e,
                       output int acc, output int waits);
      exp_t ent;
      sd[k] = d; sa[k] = a; sv[k] = 1'b1;
      waits = 0; acc = -1;
      #1;
      while (!rdy[k] && waits < 100) begin
         @(posedge clk);
         #2;
         waits++;
      end
      if (!rdy[k]) begin
         chk("accept_timeout", k, 0, 1);
         sv[k] = 1'b0;
         return;
      end
      @(posedge clk);
      acc = ncyc;
      ent.k = k; ent.d = e; ent.a = a; ent.acc = acc;
      sbq.push_back(ent);
      #1;
   endtask

   task automatic drain(input int k);
      int n = 0;
      while ((pending(k) != 0 || mv[k]) && n < 300) begin
         tick();
         n++;
      end
      if (pending(k) != 0 || mv[k]) chk("drain_timeout", k, 32'(pending(k)), 0);
   endtask

   logic [3:0] nib_exp[4];
   int acc1, acc2, w;

   initial begin
      #2000000;
      $display("FAIL watchdog inst=0 actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      nib_exp[0] = 4'h0; nib_exp[1] = 4'h8; nib_exp[2] = 4'h0; nib_exp[3] = 4'h0;
      for (int k = 0; k < 2; k++) begin
         sd[k] = '0; sa[k] = 1'b0; sv[k] = 1'b0; mr[k] = 1'b1;
      end
      rst = 1'b1;
      repeat (3) tick();

      for (int k = 0; k < 2; k++) begin
         chk("rst_busy", k, 32'(busy[k]), 0);
         chk("rst_t_reset", k, 32'(t_reset[k]), 1);
         chk("rst_t_abs", k, 32'(t_abs[k]), 0);
         chk("rst_t_nibble", k, 32'(t_nib[k]), 0);
         chk("rst_m_valid", k, 32'(mv[k]), 0);
         chk("rst_m_data", k, 32'(md[k]), 0);
      end
      rst = 1'b0;
      repeat (3) tick();

      // 1: single operation, nibble order
      send(0, 16'h0800, 1'b0, 16'h0200, acc1, w);
      sv[0] = 1'b0;
      chk("accept_wait_hold", 0, w, 0);
      for (int i = 0; i < 4; i++) begin
         chk("nibble", 0, 32'(t_nib[0]), 32'(nib_exp[i]));
         tick();
      end
      drain(0);

      // 2: back-to-back with s_valid held
      send(0, 16'h0400, 1'b0, 16'h0400, acc1, w);
      send(0, 16'h1000, 1'b0, 16'h0100, acc2, w);
      sv[0] = 1'b0;
      chk("b2b_spacing", 0, acc2 - acc1, 7);
      drain(0);

      // 3: abs on / off for a negative operand
      send(0, 16'hF800, 1'b1, 16'h0200, acc1, w);
      sv[0] = 1'b0;
      drain(0);
      send(0, 16'hF800, 1'b0, 16'hFE00, acc1, w);
      sv[0] = 1'b0;
      drain(0);

      // 4: result held under backpressure, accept on the releasing edge
      mr[0] = 1'b0;
      send(0, 16'h0800, 1'b0, 16'h0200, acc1, w);
      sd[0] = 16'h0400;
      for (int n = 0; n < 40 && !mv[0]; n++) tick();
      chk("bp_valid", 0, 32'(mv[0]), 1);
      for (int n = 0; n < 4; n++) begin
         tick();
         chk("bp_no_accept", 0, 32'(busy[0]), 0);
         chk("bp_data", 0, 32'(md[0]), 16'h0200);
      end
      mr[0] = 1'b1;
      send(0, 16'h0400, 1'b0, 16'h0400, acc2, w);
      sv[0] = 1'b0;
      chk("bp_release_accept", 0, w, 0);
      chk("bp_released", 0, 32'(mv[0]), 0);
      drain(0);

      // 5: reset during LOAD phase 2
      send(0, 16'h1000, 1'b0, 16'h0100, acc1, w);
      sv[0] = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("midrst_busy", 0, 32'(busy[0]), 0);
      chk("midrst_t_reset", 0, 32'(t_reset[0]), 1);
      chk("midrst_m_valid", 0, 32'(mv[0]), 0);
      while (find(0) >= 0) sbq.delete(find(0));
      tick();
      rst = 1'b0;
      tick();
      send(0, 16'h0800, 1'b0, 16'h0200, acc1, w);
      sv[0] = 1'b0;
      drain(0);

      // 6: IDLE_HOLD_RESET=0 instance
      repeat (3) tick();
      chk("idle_t_reset_hold", 0, 32'(t_reset[0]), 1);
      chk("idle_t_reset_pulse", 1, 32'(t_reset[1]), 0);
      send(1, 16'h0800, 1'b0, 16'h0200, acc1, w);
      chk("pulse_arm_wait", 1, w, 1);
      chk("pulse_low_in_op", 1, 32'(t_reset[1]), 0);
      send(1, 16'h0400, 1'b0, 16'h0400, acc2, w);
      sv[1] = 1'b0;
      chk("pulse_b2b_spacing", 1, acc2 - acc1, 7);
      drain(1);
      tick();
      tick();
      chk("pulse_released", 1, 32'(t_reset[1]), 0);

      // Random operands with random backpressure on both instances
      rnd_mr = 1'b1;
      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < 25; n++) begin
            logic [15:0] d;
            logic        a;
            d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
            a = 1'($urandom_range(0, 1));
            send(k, d, a, recip(d, a), acc1, w);
            sv[k] = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
         end
      end
      rnd_mr = 1'b0;
      tick();
      mr[0] = 1'b1;
      mr[1] = 1'b1;
      drain(0);
      drain(1);
      chk("scoreboard_empty", 0, 32'(sbq.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
